// File: rtl/spi_ram_pkg.sv
// spi_ram_pkg: command encoding, requester ids and arbiter state
// shared by the SPI RAM arbiter and its round-robin grant.
package spi_ram_pkg;

  localparam int CMD_W  = 10;
  localparam int DATA_W = 8;

  localparam logic [1:0] CMD_WR_ADDR = 2'b00;
  localparam logic [1:0] CMD_WR_DATA = 2'b01;
  localparam logic [1:0] CMD_RD_ADDR = 2'b10;
  localparam logic [1:0] CMD_RD_DATA = 2'b11;

  localparam logic REQ_A = 1'b0;
  localparam logic REQ_B = 1'b1;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    LOCK_A = 2'd1,
    LOCK_B = 2'd2
  } arb_state_t;

  typedef enum logic {
    LK_WR = 1'b0,
    LK_RD = 1'b1
  } lock_kind_t;

  function automatic logic is_setup(input logic [1:0] op);
    return (op == CMD_WR_ADDR) || (op == CMD_RD_ADDR);
  endfunction

  function automatic lock_kind_t kind_of(input logic [1:0] op);
    return op[1] ? LK_RD : LK_WR;
  endfunction

  function automatic logic closes(
    input logic [1:0] op,
    input lock_kind_t kind
  );
    return (op == CMD_WR_DATA && kind == LK_WR) ||
           (op == CMD_RD_DATA && kind == LK_RD);
  endfunction

endpackage

// File: rtl/spi_ram_arbiter_rr_arb2.sv
// rr_arb2: two-way round-robin grant; the requester that did not
// win last time wins a tie.
module rr_arb2
  import spi_ram_pkg::*;
(
  input  logic clk,
  input  logic rst_n,
  input  logic req_a,
  input  logic req_b,
  input  logic acc,
  input  logic acc_id,
  input  logic force_set,
  input  logic force_id,
  output logic gnt_a,
  output logic gnt_b,
  output logic last_grant
);

  always_comb begin
    gnt_a = req_a && (!req_b || last_grant == REQ_B);
    gnt_b = req_b && (!req_a || last_grant == REQ_A);
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      last_grant <= REQ_B;
    end else if (force_set) begin
      last_grant <= force_id;
    end else if (acc) begin
      last_grant <= acc_id;
    end
  end

endmodule

// File: rtl/spi_ram_arbiter.sv
// spi_ram_arbiter: shares the SPI command RAM between the SPI front-end
// (A) and the host port (B), locking across address/data pairs.
module spi_ram_arbiter
  import spi_ram_pkg::*;
#(
  parameter int LOCK_TIMEOUT = 16,
  parameter int CNT_W = $clog2(LOCK_TIMEOUT + 1)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              a_req_valid,
  input  logic [CMD_W-1:0]  a_req_cmd,
  output logic              a_req_ready,
  output logic              a_rsp_valid,
  output logic [DATA_W-1:0] a_rsp_data,
  input  logic              b_req_valid,
  input  logic [CMD_W-1:0]  b_req_cmd,
  output logic              b_req_ready,
  output logic              b_rsp_valid,
  output logic [DATA_W-1:0] b_rsp_data,
  output logic [CMD_W-1:0]  ram_din,
  output logic              ram_rx_valid,
  input  logic [DATA_W-1:0] ram_dout,
  input  logic              ram_tx_valid,
  output logic              lock_owner,
  output logic              locked,
  output logic              lock_timeout
);

  arb_state_t       state;
  lock_kind_t       kind;
  logic [CNT_W-1:0] cnt;

  logic             gnt_a;
  logic             gnt_b;
  logic             last_grant;
  logic             acc_a;
  logic             acc_b;
  logic             acc;
  logic             acc_id;
  logic [CMD_W-1:0] acc_cmd;
  logic [1:0]       acc_op;
  logic             tmo;
  logic             tmo_id;

  logic             p1_v;
  logic             p1_id;
  logic             p2_v;
  logic             p2_id;

  rr_arb2 u_rr (
    .clk        (clk),
    .rst_n      (rst_n),
    .req_a      (a_req_valid),
    .req_b      (b_req_valid),
    .acc        (acc),
    .acc_id     (acc_id),
    .force_set  (tmo),
    .force_id   (tmo_id),
    .gnt_a      (gnt_a),
    .gnt_b      (gnt_b),
    .last_grant (last_grant)
  );

  always_comb begin
    a_req_ready = 1'b0;
    b_req_ready = 1'b0;
    unique case (state)
      IDLE: begin
        a_req_ready = gnt_a;
        b_req_ready = gnt_b;
      end
      LOCK_A:  a_req_ready = a_req_valid;
      LOCK_B:  b_req_ready = b_req_valid;
      default: ;
    endcase
  end

  always_comb begin
    acc_a   = a_req_valid && a_req_ready;
    acc_b   = b_req_valid && b_req_ready;
    acc     = acc_a || acc_b;
    acc_id  = acc_b ? REQ_B : REQ_A;
    acc_cmd = acc_b ? b_req_cmd : a_req_cmd;
    acc_op  = acc_cmd[CMD_W-1 -: 2];
  end

  // A silent lock is dropped once it has idled LOCK_TIMEOUT cycles.
  always_comb begin
    tmo    = (state != IDLE) && !acc &&
             (cnt == CNT_W'(LOCK_TIMEOUT - 1));
    tmo_id = (state == LOCK_B) ? REQ_B : REQ_A;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state        <= IDLE;
      kind         <= LK_WR;
      cnt          <= '0;
      lock_timeout <= 1'b0;
      locked       <= 1'b0;
      lock_owner   <= REQ_A;
    end else begin
      lock_timeout <= tmo;
      if (state == IDLE) begin
        cnt <= '0;
        if (acc && is_setup(acc_op)) begin
          state      <= acc_id ? LOCK_B : LOCK_A;
          kind       <= kind_of(acc_op);
          locked     <= 1'b1;
          lock_owner <= acc_id;
        end
      end else if (acc) begin
        cnt <= '0;
        if (closes(acc_op, kind)) begin
          state  <= IDLE;
          locked <= 1'b0;
        end else if (is_setup(acc_op)) begin
          kind <= kind_of(acc_op);
        end
      end else if (tmo) begin
        state  <= IDLE;
        locked <= 1'b0;
        cnt    <= '0;
      end else begin
        cnt <= cnt + CNT_W'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      ram_rx_valid <= 1'b0;
      ram_din      <= '0;
    end else begin
      ram_rx_valid <= acc;
      if (acc) begin
        ram_din <= acc_cmd;
      end
    end
  end

  // Owner ids ride alongside the two-cycle RAM read latency.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      p1_v  <= 1'b0;
      p1_id <= REQ_A;
      p2_v  <= 1'b0;
      p2_id <= REQ_A;
    end else begin
      p1_v  <= acc && (acc_op == CMD_RD_DATA);
      p1_id <= acc_id;
      p2_v  <= p1_v;
      p2_id <= p1_id;
    end
  end

  always_comb begin
    a_rsp_valid = ram_tx_valid && p2_v && (p2_id == REQ_A);
    b_rsp_valid = ram_tx_valid && p2_v && (p2_id == REQ_B);
    a_rsp_data  = a_rsp_valid ? ram_dout : '0;
    b_rsp_data  = b_rsp_valid ? ram_dout : '0;
  end

endmodule

// File: tb/tb_spi_ram_arbiter.sv
// tb_spi_ram_arbiter: directed scenarios plus random traffic checked
// against a transaction-level model of arbitration, locking and reads.
module tb_spi_ram_arbiter;
  import spi_ram_pkg::*;

  localparam int LT = 16;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       a_req_valid, b_req_valid;
  logic [9:0] a_req_cmd, b_req_cmd;
  logic       a_req_ready, b_req_ready;
  logic       a_rsp_valid, b_rsp_valid;
  logic [7:0] a_rsp_data, b_rsp_data;
  logic [9:0] ram_din;
  logic       ram_rx_valid;
  bit   [7:0] ram_dout = 8'hC3;
  bit         ram_tx_valid = 1'b0;
  logic       lock_owner, locked, lock_timeout;

  always #5 clk = ~clk;

  spi_ram_arbiter #(.LOCK_TIMEOUT(LT)) dut (
    .clk(clk), .rst_n(rst_n),
    .a_req_valid(a_req_valid), .a_req_cmd(a_req_cmd),
    .a_req_ready(a_req_ready), .a_rsp_valid(a_rsp_valid),
    .a_rsp_data(a_rsp_data),
    .b_req_valid(b_req_valid), .b_req_cmd(b_req_cmd),
    .b_req_ready(b_req_ready), .b_rsp_valid(b_rsp_valid),
    .b_rsp_data(b_rsp_data),
    .ram_din(ram_din), .ram_rx_valid(ram_rx_valid),
    .ram_dout(ram_dout), .ram_tx_valid(ram_tx_valid),
    .lock_owner(lock_owner), .locked(locked),
    .lock_timeout(lock_timeout)
  );

  function automatic logic [7:0] init_val(input int i);
    return 8'((i * 37 + 5) & 255);
  endfunction

  // RAM: samples a command the cycle it is strobed, answers a read one later.
  bit   [7:0] ram [256];
  bit   [7:0] ram_wa, ram_ra;
  bit         booted = 1'b0;
  always @(posedge clk) begin
    ram_tx_valid <= 1'b0;
    if (!booted) begin
      foreach (ram[i]) ram[i] <= init_val(i);
      booted <= 1'b1;
    end else if (ram_rx_valid) begin
      case (ram_din[9:8])
        2'b00: ram_wa <= ram_din[7:0];
        2'b01: ram[ram_wa] <= ram_din[7:0];
        2'b10: ram_ra <= ram_din[7:0];
        default: begin
          ram_dout     <= ram[ram_ra];
          ram_tx_valid <= 1'b1;
        end
      endcase
    end
  end

  typedef struct {
    int       due;
    bit       id;
    bit [7:0] d;
  } rsp_t;

  int       tests = 0, fails = 0, cyc = 0;
  int       m_owner, m_idle;
  bit       m_rd, m_last, m_lo, exp_tmo, exp_rxv;
  bit [9:0] exp_din;
  bit [7:0] mem [256];
  bit [7:0] m_wa, m_ra;
  rsp_t     q[$];
  bit       grants[$];
  bit       acc_a_o, acc_b_o;

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_owner = -1; m_idle = 0; m_rd = 0; m_last = 1'b1; m_lo = 1'b0;
    exp_tmo = 0; exp_rxv = 0; exp_din = '0;
    q.delete();
  endtask

  task automatic do_reset(input int n);
    a_req_valid = 0; b_req_valid = 0; rst_n = 0;
    repeat (n) @(posedge clk);
    @(negedge clk);
    rst_n = 1; cyc += n;
    model_reset();
    chk("rst_rx_valid", ram_rx_valid, 0);
    chk("rst_din", ram_din, 0);
    chk("rst_locked", locked, 0);
    chk("rst_owner", lock_owner, 0);
    chk("rst_tmo", lock_timeout, 0);
    chk("rst_a_rsp_v", a_rsp_valid, 0);
    chk("rst_b_rsp_v", b_rsp_valid, 0);
    chk("rst_a_rsp_d", a_rsp_data, 0);
    chk("rst_b_rsp_d", b_rsp_data, 0);
  endtask

  // One clock: check readies, advance the model, check what follows.
  task automatic step();
    bit ra, rb, id, ea, eb;
    bit [9:0] cmd;
    bit [1:0] op;
    bit [7:0] da, db;
    rsp_t r;
    #1;
    if (m_owner < 0) begin
      if (a_req_valid && b_req_valid) begin
        ra = (m_last == REQ_B); rb = !ra;
      end else begin
        ra = a_req_valid; rb = b_req_valid;
      end
    end else begin
      ra = (m_owner == 0) && a_req_valid;
      rb = (m_owner == 1) && b_req_valid;
    end
    chk("a_ready", a_req_ready, ra);
    chk("b_ready", b_req_ready, rb);
    tests++;
    assert (!(a_req_ready && b_req_ready)) else begin
      fails++;
      $error("FAIL both_ready: a=%0b b=%0b required not both", a_req_ready,
             b_req_ready);
    end
    acc_a_o = ra; acc_b_o = rb;
    exp_rxv = ra || rb; exp_tmo = 0;
    if (ra || rb) begin
      id = rb; cmd = rb ? b_req_cmd : a_req_cmd; op = cmd[9:8];
      exp_din = cmd; m_last = id; grants.push_back(id); m_idle = 0;
      case (op)
        2'b00: m_wa = cmd[7:0];
        2'b01: mem[m_wa] = cmd[7:0];
        2'b10: m_ra = cmd[7:0];
        default: begin
          r.due = cyc + 2; r.id = id; r.d = mem[m_ra];
          q.push_back(r);
        end
      endcase
      if (m_owner < 0) begin
        if (op == 2'b00 || op == 2'b10) begin
          m_owner = int'(id); m_lo = id; m_rd = (op == 2'b10);
        end
      end else if ((op == 2'b01 && !m_rd) || (op == 2'b11 && m_rd)) begin
        m_owner = -1;
      end else if (op == 2'b00) begin
        m_rd = 0;
      end else if (op == 2'b10) begin
        m_rd = 1;
      end
    end else if (m_owner >= 0) begin
      m_idle++;
      if (m_idle == LT) begin
        exp_tmo = 1; m_last = m_owner[0]; m_owner = -1; m_idle = 0;
      end
    end
    @(posedge clk);
    @(negedge clk);
    cyc++;
    chk("rx_valid", ram_rx_valid, exp_rxv);
    chk("din", ram_din, exp_din);
    chk("locked", locked, m_owner >= 0);
    chk("lock_owner", lock_owner, m_lo);
    chk("lock_timeout", lock_timeout, exp_tmo);
    ea = 0; eb = 0; da = 0; db = 0;
    while (q.size() > 0 && q[0].due <= cyc) begin
      r = q.pop_front();
      if (r.due == cyc) begin
        if (r.id) begin eb = 1; db = r.d; end
        else begin ea = 1; da = r.d; end
      end
    end
    chk("a_rsp_valid", a_rsp_valid, ea);
    chk("a_rsp_data", a_rsp_data, da);
    chk("b_rsp_valid", b_rsp_valid, eb);
    chk("b_rsp_data", b_rsp_data, db);
  endtask

  function automatic logic [9:0] gen_cmd();
    logic [1:0] op;
    op = 2'($urandom_range(0, 3));
    if (op == 2'b01) return {op, 8'($urandom_range(0, 255))};
    return {op, 8'($urandom_range(0, 15))};
  endfunction

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int n, ca, cb, qa, qb;
    foreach (mem[i]) mem[i] = init_val(i);
    a_req_cmd = '0; b_req_cmd = '0;
    do_reset(3);

    // A's write pair holds off B's pending address setup.
    a_req_valid = 1; a_req_cmd = 10'h012;
    b_req_valid = 1; b_req_cmd = 10'h034;
    step(); chk("t1_din0", ram_din, 10'h012);
    a_req_cmd = 10'h1AB;
    step(); chk("t1_din1", ram_din, 10'h1AB);
    a_req_valid = 0;
    step(); chk("t1_din2", ram_din, 10'h034);
    b_req_cmd = 10'h177;
    step(); b_req_valid = 0;
    step();

    // Read back 0xAB from 0x12 through A.
    a_req_valid = 1; a_req_cmd = 10'h212;
    step(); a_req_cmd = 10'h300;
    step(); a_req_valid = 0;
    step();
    chk("t2_a_rsp_v", a_rsp_valid, 1);
    chk("t2_a_rsp_d", a_rsp_data, 8'hAB);
    chk("t2_b_rsp_v", b_rsp_valid, 0);

    // Back-to-back reads from A then B.
    a_req_valid = 1; a_req_cmd = 10'h300;
    step(); a_req_valid = 0;
    b_req_valid = 1; b_req_cmd = 10'h300;
    step(); b_req_valid = 0;
    chk("t6_a_rsp_v", a_rsp_valid, 1);
    chk("t6_a_rsp_d", a_rsp_data, 8'hAB);
    step();
    chk("t6_b_rsp_v", b_rsp_valid, 1);
    chk("t6_b_rsp_d", b_rsp_data, 8'hAB);
    chk("t6_a_quiet", a_rsp_valid, 0);

    // Reset between A's read setup and its data beat.
    a_req_valid = 1; a_req_cmd = 10'h212;
    step(); chk("t5_locked", locked, 1);
    do_reset(1);
    b_req_valid = 1; b_req_cmd = 10'h050;
    step(); chk("t5_b_first", ram_din, 10'h050);
    b_req_cmd = 10'h166;
    step(); b_req_valid = 0;
    step();
    // An in-flight read is dropped by reset.
    a_req_valid = 1; a_req_cmd = 10'h300;
    step();
    do_reset(1);

    // Continuous reads from both alternate A, B, A, B.
    grants.delete(); ca = 0; cb = 0;
    a_req_valid = 1; a_req_cmd = 10'h300;
    b_req_valid = 1; b_req_cmd = 10'h300;
    for (int i = 0; i < 8; i++) begin
      if (i == 6) begin a_req_valid = 0; b_req_valid = 0; end
      step();
      ca += int'(a_rsp_valid); cb += int'(b_rsp_valid);
    end
    chk("t3_ngrants", grants.size(), 6);
    for (int i = 0; i < grants.size() && i < 6; i++)
      chk("t3_grant", grants[i], i % 2);
    chk("t3_a_rsps", ca, 3);
    chk("t3_b_rsps", cb, 3);

    // A stalls inside its lock while B waits.
    a_req_valid = 1; a_req_cmd = 10'h040;
    b_req_valid = 1; b_req_cmd = 10'h300;
    step(); a_req_valid = 0;
    n = 0;
    do begin step(); n++; end while (!lock_timeout && n < 40);
    chk("t4_tmo_delay", n, 16);
    chk("t4_b_ready", b_req_ready, 1);
    step(); b_req_valid = 0;
    chk("t4_b_din", ram_din, 10'h300);
    step(); step();

    // Random traffic against the model.
    qa = 0; qb = 0;
    for (int k = 0; k < 2000; k++) begin
      if ($urandom_range(0, 299) == 0) begin
        do_reset(1); qa = 0; qb = 0;
      end
      if (!a_req_valid) begin
        if (qa > 0) qa--;
        else if ($urandom_range(0, 99) < 5) qa = $urandom_range(10, 24);
        else if ($urandom_range(0, 99) < 65) begin
          a_req_valid = 1; a_req_cmd = gen_cmd();
        end
      end
      if (!b_req_valid) begin
        if (qb > 0) qb--;
        else if ($urandom_range(0, 99) < 5) qb = $urandom_range(10, 24);
        else if ($urandom_range(0, 99) < 65) begin
          b_req_valid = 1; b_req_cmd = gen_cmd();
        end
      end
      step();
      if (acc_a_o) a_req_valid = 0;
      if (acc_b_o) b_req_valid = 0;
    end
    a_req_valid = 0; b_req_valid = 0;
    step(); step(); step();

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/spi_ram_arbiter.md
Name: spi_ram_arbiter

Overview:
- Shares the single-port SPI-side command RAM between two requesters: A, the SPI slave front-end, and B, the local host/debug port.
- Both requesters issue the same 10-bit command words: din[9:8] opcode, din[7:0] address or data.
- Serialises commands onto the RAM's din/rx_valid interface and routes each read-data response back to the requester that issued it.
- Locks the RAM to one requester across an address-setup/data pair, so the other requester cannot corrupt the shared write_addr or read_addr.

Parameters:
- LOCK_TIMEOUT, 16: idle cycles allowed in a locked state before the lock is forcibly released; must be at least 1.
- CNT_W, $clog2(LOCK_TIMEOUT+1): width of the lock timeout counter (derived; not to be overridden).

Ports:
- clk  in  1  clock
- rst_n  in  1  reset, synchronous, active-low
- a_req_valid  in  1  requester A command valid
- a_req_cmd  in  10  requester A command {opcode[1:0], payload[7:0]}
- a_req_ready  out  1  requester A command accepted this cycle
- a_rsp_valid  out  1  read data valid for A
- a_rsp_data  out  8  read data for A
- b_req_valid, b_req_cmd, b_req_ready, b_rsp_valid, b_rsp_data: same as the A ports, for requester B
- ram_din  out  10  command to RAM (registered)
- ram_rx_valid  out  1  command strobe to RAM (registered)
- ram_dout  in  8  RAM read data
- ram_tx_valid  in  1  RAM read data valid
- lock_owner  out  1  0=A, 1=B; meaningful only while locked
- locked  out  1  high in LOCK_A or LOCK_B
- lock_timeout  out  1  one-cycle pulse when a lock is forcibly released

Behaviour:
- Opcodes:
  - 00 WR_ADDR: write-address setup
  - 01 WR_DATA: write data
  - 10 RD_ADDR: read-address setup
  - 11 RD_DATA: read data, which returns a response
- Reset values:
  - state=IDLE, last_grant=B (so A wins the first tie)
  - ram_rx_valid=0, ram_din=0
  - timeout counter=0, lock_timeout=0
  - response owner pipeline cleared
  - all rsp_valid=0, rsp_data=0
  - locked=0, lock_owner=0
- Acceptance and issue:
  - A beat is accepted when x_req_valid && x_req_ready.
  - At most one beat is accepted per cycle.
  - The accepted command appears on ram_din with ram_rx_valid=1 on the next cycle.
  - ram_rx_valid=0 in any cycle after no acceptance.
  - x_req_ready is combinational from the valids and the state; the requester must hold valid and cmd stable until ready.
- IDLE:
  - Only one requester valid: that requester gets ready=1.
  - Both valid: the requester not equal to last_grant gets ready; last_grant updates on every acceptance.
  - Accepted opcode 00 or 10: go to LOCK_<owner> and record lock type (WR for 00, RD for 10).
  - Accepted opcode 01 or 11: stay in IDLE.
- LOCK_x:
  - Only x may be ready; the other requester's ready=0.
  - An accepted 01 while lock type is WR, or an accepted 11 while lock type is RD, returns to IDLE.
  - Any other accepted beat keeps the lock; an accepted 00 sets type to WR and an accepted 10 sets type to RD.
- Timeout:
  - In LOCK_x the counter increments each cycle with no accepted beat and clears on any accepted beat.
  - When the counter reaches LOCK_TIMEOUT: go to IDLE, pulse lock_timeout, clear the counter, set last_grant to x.
- Response routing:
  - Each accepted 11 pushes its owner id into a 2-stage owner pipeline aligned with the RAM latency: accept at T, RAM sample at T+1, ram_tx_valid at T+2.
  - x_rsp_valid = ram_tx_valid && pipe_stage2_owner==x && pipe_stage2_valid.
  - x_rsp_data = ram_dout when x_rsp_valid is 1, otherwise 0.
  - Back-to-back reads are legal; each response is routed independently.
  - ram_tx_valid with no pipeline entry is dropped.
- Reset mid-operation: the lock is released and the pipeline cleared, so in-flight responses are suppressed.
- A state where both requesters hold ready=1 is illegal; assert this in the bench.

Decomposition:
- Shared package spi_ram_pkg:
  - opcode constants CMD_WR_ADDR=2'b00, CMD_WR_DATA=2'b01, CMD_RD_ADDR=2'b10, CMD_RD_DATA=2'b11
  - requester id constants REQ_A=1'b0, REQ_B=1'b1
  - arbiter state encoding (IDLE, LOCK_A, LOCK_B)
  - CMD_W=10, DATA_W=8
- One sub-module, rr_arb2: a 2-way round-robin grant with the last_grant pointer, combinational grant and registered pointer update.
- Lock FSM, timeout counter and response pipeline stay in the top module.

Test Plan:
- A sends 00/0x12 then 01/0xAB while B holds 00/0x34 valid: B ready=0 until A's 01 is accepted; ram_din sequence is 0x012, 0x1AB, then 0x034.
- A sends 10/0x12 then 11/xx against a RAM model holding 0xAB at 0x12: a_rsp_valid=1 with a_rsp_data=0xAB exactly 2 cycles after the 11 is accepted; b_rsp_valid stays 0.
- Both send opcode 11 continuously from IDLE after reset: grants alternate A, B, A, B; responses alternate a_rsp/b_rsp with no drops.
- A sends 00 then stalls with LOCK_TIMEOUT=16 and B valid: lock_timeout pulses 16 cycles after the 00 is accepted; B is accepted the following cycle.
- rst_n=0 for one cycle between A's 10 and 11 acceptance: locked=0, ram_rx_valid=0, no rsp_valid; on release, B is granted first if A was the last grant.
- Interleave A 11 then B 11 back-to-back: a_rsp_valid at T+2 and b_rsp_valid at T+3, each carrying the correct RAM data.
